reg_file_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port register file between the system controller (requester 0) and an auxiliary configuration/debug master (requester 1). It accepts one read or write command at a time, drives the register file's `wr_en`/`rd_en`/`addres`/`wr_data` strobes from registered outputs, waits for `rd_d_valid` on reads, and returns the read data to the winning requester. Grants alternate round-robin between the two requesters so that neither can starve the other. The block sits between the requesters and the register file, in the same clock domain as the register file.

---
 rtl/reg_file_arbiter.sv | 176 +++++++++++++++++
 tb/tb_reg_file_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one single-port register file between two requesters.
// Optional read-wait timeout is enabled by defining RF_ARB_TIMEOUT_EN.
module reg_file_arbiter #(
  parameter int data_width     = 8,
  parameter int addre_width    = 4,
  parameter int timeout_cycles = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic                   req0_we,
  input  logic [addre_width-1:0] req0_addr,
  input  logic [data_width-1:0]  req0_wdata,
  input  logic                   req1_valid,
  input  logic                   req1_we,
  input  logic [addre_width-1:0] req1_addr,
  input  logic [data_width-1:0]  req1_wdata,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rsp0_valid,
  output logic                   rsp1_valid,
  output logic [data_width-1:0]  rsp_data,
  output logic                   rsp_err,
  output logic                   wr_en,
  output logic                   rd_en,
  output logic [addre_width-1:0] addres,
  output logic [data_width-1:0]  wr_data,
  input  logic [data_width-1:0]  rd_data,
  input  logic                   rd_d_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_reg;
  logic                   prio_reg;
  logic                   id_reg;
  logic [1:0]             gnt_reg;
  logic [1:0]             rsp_valid_reg;
  logic                   wr_en_reg;
  logic                   rd_en_reg;
  logic                   busy_reg;
  logic [addre_width-1:0] addr_reg;
  logic [data_width-1:0]  wdata_reg;
  logic [data_width-1:0]  rsp_data_reg;

  logic                   sel_id;
  logic                   sel_we;
  logic [addre_width-1:0] sel_addr;
  logic [data_width-1:0]  sel_wdata;

`ifdef RF_ARB_TIMEOUT_EN
  localparam int cnt_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  logic [cnt_w-1:0] cnt_reg;
  logic             rsp_err_reg;
`else
  // The limit has no effect without the timeout; keep the parameter referenced.
  if (timeout_cycles < 0) begin : g_timeout_unused
  end
`endif

  // With a single request the lone requester wins; priority breaks ties only.
  always_comb begin
    sel_id = req1_valid;
    if (req0_valid && req1_valid) begin
      sel_id = prio_reg;
    end
    sel_we    = sel_id ? req1_we    : req0_we;
    sel_addr  = sel_id ? req1_addr  : req0_addr;
    sel_wdata = sel_id ? req1_wdata : req0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      prio_reg      <= 1'b0;
      id_reg        <= 1'b0;
      gnt_reg       <= '0;
      rsp_valid_reg <= '0;
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_data_reg  <= '0;
`ifdef RF_ARB_TIMEOUT_EN
      cnt_reg       <= '0;
      rsp_err_reg   <= 1'b0;
`endif
    end else begin
      gnt_reg       <= '0;
      rsp_valid_reg <= '0;
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
      rsp_err_reg   <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            id_reg    <= sel_id;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
            // Strobes for ISSUE are loaded here so they appear registered in that cycle.
            if (sel_we) begin
              wr_en_reg       <= 1'b1;
              gnt_reg[sel_id] <= 1'b1;
              prio_reg        <= ~sel_id;
            end else begin
              rd_en_reg <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (wr_en_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= WAIT;
`ifdef RF_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
          end
        end
        WAIT: begin
          if (rd_d_valid) begin
            rsp_data_reg          <= rd_data;
            gnt_reg[id_reg]       <= 1'b1;
            rsp_valid_reg[id_reg] <= 1'b1;
            prio_reg              <= ~id_reg;
            state_reg             <= RESP;
          end
`ifdef RF_ARB_TIMEOUT_EN
          else if (cnt_reg == cnt_w'(timeout_cycles - 1)) begin
            rsp_data_reg          <= '1;
            rsp_err_reg           <= 1'b1;
            gnt_reg[id_reg]       <= 1'b1;
            rsp_valid_reg[id_reg] <= 1'b1;
            prio_reg              <= ~id_reg;
            state_reg             <= RESP;
          end else begin
            cnt_reg <= cnt_reg + cnt_w'(1);
          end
`endif
        end
        RESP: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0       = gnt_reg[0];
  assign gnt1       = gnt_reg[1];
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp_data   = rsp_data_reg;
  assign wr_en      = wr_en_reg;
  assign rd_en      = rd_en_reg;
  assign addres     = addr_reg;
  assign wr_data    = wdata_reg;
  assign busy       = busy_reg;
`ifdef RF_ARB_TIMEOUT_EN
  assign rsp_err    = rsp_err_reg;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: table-driven single transactions plus arbitration,
// reset and stray-valid sequences; grants are scored against an expectation queue.
module tb_reg_file_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [3:0] req0_addr = '0;
  logic [7:0] req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [3:0] req1_addr = '0;
  logic [7:0] req1_wdata = '0;
  logic       gnt0, gnt1, rsp0_valid, rsp1_valid, rsp_err;
  logic [7:0] rsp_data;
  logic       wr_en, rd_en, busy;
  logic [3:0] addres;
  logic [7:0] wr_data;
  logic [7:0] rd_data = '0;
  logic       rd_d_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       id;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic       id;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic [7:0] rdata;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  reg_file_arbiter #(.data_width(8), .addre_width(4), .timeout_cycles(15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .gnt0(gnt0), .gnt1(gnt1), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .wr_en(wr_en), .rd_en(rd_en),
    .addres(addres), .wr_data(wr_data), .rd_data(rd_data), .rd_d_valid(rd_d_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic we,
                         input logic [3:0] addr, input logic [7:0] wdata);
    if (id) begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  // Scoreboard: every grant must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      if (q.size() == 0) begin
        check("spurious_gnt", 32'({gnt1, gnt0}), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("gnt_id", 32'({gnt1, gnt0}), e.id ? 32'd2 : 32'd1);
        check("rsp_valid", 32'({rsp1_valid, rsp0_valid}), e.rd ? (e.id ? 32'd2 : 32'd1) : 32'd0);
        if (e.rd) begin
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end else begin
          check("wr_with_gnt", 32'({wr_en, addres, wr_data}), 32'({1'b1, e.addr, e.data}));
        end
        $display("txn gnt%0d %s addr=%0h data=%0h err=%0b", e.id, e.rd ? "rd" : "wr",
                 e.addr, e.rd ? rsp_data : wr_data, rsp_err);
      end
    end else begin
      check("rsp_without_gnt", 32'({rsp1_valid, rsp0_valid, rsp_err}), 32'd0);
    end
  end

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    set_req(v.id, 1'b1, v.we, v.addr, v.wdata);
    q.push_back('{id: v.id, rd: !v.we, addr: v.addr, data: v.exp_data, err: 1'b0});
    @(negedge clk);
    if (v.we) begin
      check("wr_strobe", 32'({wr_en, rd_en, addres, wr_data}), 32'({1'b1, 1'b0, v.addr, v.exp_data}));
      check("wr_gnt_now", 32'(v.id ? gnt1 : gnt0), 32'd1);
      set_req(v.id, 1'b0, 1'b0, 4'h0, 8'h00);
      @(negedge clk);
      check("wr_then_idle", 32'({busy, wr_en}), 32'd0);
    end else begin
      check("rd_strobe", 32'({rd_en, wr_en, addres}), 32'({1'b1, 1'b0, v.addr}));
      for (int k = 1; k <= v.lat; k++) begin
        @(negedge clk);
      end
      check("rd_wait_busy", 32'({busy, gnt0, gnt1}), 32'h4);
      rd_d_valid = 1'b1;
      rd_data    = v.rdata;
      @(negedge clk);
      rd_d_valid = 1'b0;
      rd_data    = 8'h00;
      check("rd_gnt_now", 32'(v.id ? gnt1 : gnt0), 32'd1);
      set_req(v.id, 1'b0, 1'b0, 4'h0, 8'h00);
      @(negedge clk);
      check("rd_then_idle", 32'(busy), 32'd0);
      check("rsp_hold", 32'(rsp_data), 32'(v.rdata));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{id: 1'b0, we: 1'b1, addr: 4'h3, wdata: 8'h5A, lat: 0, rdata: 8'h00, exp_data: 8'h5A};
    vecs[1] = '{id: 1'b1, we: 1'b0, addr: 4'h7, wdata: 8'h00, lat: 3, rdata: 8'hC3, exp_data: 8'hC3};
    vecs[2] = '{id: 1'b0, we: 1'b0, addr: 4'hA, wdata: 8'h00, lat: 1, rdata: 8'h11, exp_data: 8'h11};
    vecs[3] = '{id: 1'b1, we: 1'b1, addr: 4'hF, wdata: 8'hA5, lat: 0, rdata: 8'h00, exp_data: 8'hA5};
    vecs[4] = '{id: 1'b1, we: 1'b0, addr: 4'hE, wdata: 8'h00, lat: 2, rdata: 8'hFF, exp_data: 8'hFF};
    vecs[5] = '{id: 1'b0, we: 1'b0, addr: 4'h0, wdata: 8'h00, lat: 5, rdata: 8'h96, exp_data: 8'h96};

    // Both requesters hold writes through reset; check reset state.
    set_req(1'b0, 1'b1, 1'b1, 4'h1, 8'h10);
    set_req(1'b1, 1'b1, 1'b1, 4'h2, 8'h20);
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({gnt1, gnt0, rsp1_valid, rsp0_valid, rsp_err, wr_en, rd_en, busy,
                                addres, wr_data, rsp_data}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      q.push_back('{id: i[0], rd: 1'b0, addr: i[0] ? 4'h2 : 4'h1, data: i[0] ? 8'h20 : 8'h10, err: 1'b0});
    end
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c[0] == 1'b0) begin
        check("rr_gnt", 32'({gnt1, gnt0}), (c % 4 == 0) ? 32'd1 : 32'd2);
      end else begin
        check("rr_gap", 32'({gnt1, gnt0, busy}), 32'd0);
      end
      if (c == 6) begin
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      end
    end
    check("rr_drained", 32'(q.size()), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i]);
    end

    // Reset while in WAIT (last grant went to 0, so priority was with 1).
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 4'h4, 8'h00);
    @(negedge clk);
    check("wr_rd_en", 32'(rd_en), 32'd1);
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    q.delete();
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("mid_reset_outputs", 32'({gnt1, gnt0, rsp1_valid, rsp0_valid, rsp_err, wr_en, rd_en, busy,
                                    addres, wr_data, rsp_data}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, 4'h5, 8'h55);
    set_req(1'b1, 1'b1, 1'b1, 4'h6, 8'h66);
    q.push_back('{id: 1'b0, rd: 1'b0, addr: 4'h5, data: 8'h55, err: 1'b0});
    @(negedge clk);
    check("post_reset_prio", 32'({gnt1, gnt0}), 32'd1);
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);

    // rd_d_valid in IDLE and in ISSUE must be ignored.
    rd_d_valid = 1'b1; rd_data = 8'h77;
    @(negedge clk);
    rd_d_valid = 1'b0; rd_data = 8'h00;
    check("idle_valid_ignored", 32'({busy, rsp_data}), 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 4'h9, 8'h00);
    q.push_back('{id: 1'b1, rd: 1'b1, addr: 4'h9, data: 8'h3C, err: 1'b0});
    @(negedge clk);
    rd_d_valid = 1'b1; rd_data = 8'h66;
    @(negedge clk);
    rd_d_valid = 1'b0; rd_data = 8'h00;
    @(negedge clk);
    check("issue_valid_ignored", 32'({busy, gnt1, rsp1_valid, rsp_data}), 32'h400);
    rd_d_valid = 1'b1; rd_data = 8'h3C;
    @(negedge clk);
    rd_d_valid = 1'b0; rd_data = 8'h00;
    check("late_valid_gnt", 32'({gnt1, rsp1_valid, rsp_data}), 32'h33C);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);

    // Read that never gets rd_d_valid.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 4'h2, 8'h00);
`ifdef RF_ARB_TIMEOUT_EN
    q.push_back('{id: 1'b0, rd: 1'b1, addr: 4'h2, data: 8'hFF, err: 1'b1});
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
    end
    check("tmo_not_yet", 32'({gnt0, rsp_err, busy}), 32'd1);
    @(negedge clk);
    check("tmo_resp", 32'({gnt0, rsp0_valid, rsp_err, rsp_data}), 32'h7FF);
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    check("tmo_idle", 32'(busy), 32'd0);
`else
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
    end
    check("no_tmo_stuck", 32'({busy, gnt0, rsp0_valid}), 32'h4);
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
